// File: rtl/corevx_storegen.sv
// corevx_storegen: store request decode, word-aligned bus write and completion report.
// Accepts one store in IDLE, rejects unknown/misaligned stores locally, otherwise
// issues a single valid/ready write and waits for the bus response.
module corevx_storegen (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_resp_valid,
  input  logic        m_resp_error,
  output logic        done_valid,
  output logic        done_missaligned,
  output logic        done_unknown_type,
  output logic        done_access_fault
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUS_REQ  = 2'd1,
    S_BUS_RESP = 2'd2,
    S_ERR      = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_m_valid;
  logic [AW-1:0]   r_m_addr;
  logic [DW-1:0]   r_m_wdata;
  logic [SW-1:0]   r_m_wstrb;
  logic            r_done_valid;
  logic            r_done_mis;
  logic            r_done_unk;
  logic            r_done_fault;

  logic [1:0]      w_off;
  logic            w_unknown;
  logic            w_misaligned;
  logic [SW-1:0]   w_strb;
  logic [DW-1:0]   w_wdata;

  assign w_off = req_addr[1:0];

  // Decode the incoming request into error flags and bus write fields.
  always_comb begin
    w_unknown    = 1'b0;
    w_misaligned = 1'b0;
    w_strb       = '0;
    w_wdata      = '0;
    case (req_type)
      3'b000: begin
        w_strb  = SW'(4'b0001 << w_off);
        w_wdata = {4{req_data[7:0]}};
      end
      3'b001: begin
        w_misaligned = req_addr[0];
        w_strb       = SW'(4'b0011 << w_off);
        w_wdata      = {2{req_data[15:0]}};
      end
      3'b010: begin
        w_misaligned = |req_addr[1:0];
        w_strb       = 4'b1111;
        w_wdata      = req_data;
      end
      default: begin
        // Unknown type wins over misalignment, so misaligned stays 0 here.
        w_unknown = 1'b1;
      end
    endcase
  end

  // Control FSM with registered bus and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_m_valid    <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_wstrb    <= '0;
      r_done_valid <= 1'b0;
      r_done_mis   <= 1'b0;
      r_done_unk   <= 1'b0;
      r_done_fault <= 1'b0;
    end else begin
      // Completion is a single-cycle pulse; flags are only meaningful with it.
      r_done_valid <= 1'b0;
      r_done_mis   <= 1'b0;
      r_done_unk   <= 1'b0;
      r_done_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_unknown || w_misaligned) begin
              r_state      <= S_ERR;
              r_done_valid <= 1'b1;
              r_done_unk   <= w_unknown;
              r_done_mis   <= w_misaligned;
            end else begin
              r_state   <= S_BUS_REQ;
              r_m_valid <= 1'b1;
              r_m_addr  <= {req_addr[AW-1:2], 2'b00};
              r_m_wdata <= w_wdata;
              r_m_wstrb <= w_strb;
            end
          end
        end
        S_BUS_REQ: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= S_BUS_RESP;
          end
        end
        S_BUS_RESP: begin
          if (m_resp_valid) begin
            r_done_valid <= 1'b1;
            r_done_fault <= m_resp_error;
            r_state      <= S_IDLE;
          end
        end
        S_ERR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready         = (r_state == S_IDLE);
  assign m_valid           = r_m_valid;
  assign m_addr            = r_m_addr;
  assign m_wdata           = r_m_wdata;
  assign m_wstrb           = r_m_wstrb;
  assign done_valid        = r_done_valid;
  assign done_missaligned  = r_done_mis;
  assign done_unknown_type = r_done_unk;
  assign done_access_fault = r_done_fault;

endmodule

// File: tb/tb_corevx_storegen.sv
// Testbench for corevx_storegen: directed vector table, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_corevx_storegen;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_resp_valid;
  logic        m_resp_error;
  logic        done_valid;
  logic        done_missaligned;
  logic        done_unknown_type;
  logic        done_access_fault;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;
  int exp_done  = 0;
  logic mon_en = 1'b0;

  corevx_storegen dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_type          (req_type),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_addr            (m_addr),
    .m_wdata           (m_wdata),
    .m_wstrb           (m_wstrb),
    .m_resp_valid      (m_resp_valid),
    .m_resp_error      (m_resp_error),
    .done_valid        (done_valid),
    .done_missaligned  (done_missaligned),
    .done_unknown_type (done_unknown_type),
    .done_access_fault (done_access_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    int          rdly;
    int          pdly;
    logic        perr;
    logic        exp_mis;
    logic        exp_unk;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Store semantics from access size and byte offset, independent of the RTL decode.
  function automatic void model(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                                output logic mis, output logic unk,
                                output logic [3:0] strb, output logic [31:0] wd);
    int size;
    int off;
    unk  = (t > 3'd2);
    mis  = 1'b0;
    strb = '0;
    wd   = '0;
    if (!unk) begin
      size = 1 << t;
      off  = int'(a % 32'd4);
      mis  = (off % size) != 0;
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + size) strb[i] = 1'b1;
        wd[8*i +: 8] = d[8*(i % size) +: 8];
      end
    end
  endfunction

  // Done monitor: count pulses and require flags low whenever no pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done_valid === 1'b1) done_seen++;
      else chk("flags_idle", {29'd0, done_missaligned, done_unknown_type, done_access_fault}, 32'd0);
    end
  end

  // One complete transaction from IDLE, back to IDLE; called 1ns after an edge.
  task automatic run_txn(input string tag, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] d, input int rdly, input int pdly, input logic perr,
                         input logic mis, input logic unk, input logic [3:0] strb,
                         input logic [31:0] wd);
    logic [31:0] exp_addr;
    exp_addr = a & 32'hFFFF_FFFC;
    chk({tag, ":req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_type = t; req_addr = a; req_data = d;
    tick();
    // Request inputs change after acceptance and must not affect the transaction.
    req_valid = 1'b0; req_type = 3'($urandom); req_addr = $urandom; req_data = $urandom;
    if (mis || unk) begin
      chk({tag, ":err_done"}, {31'd0, done_valid}, 32'd1);
      chk({tag, ":err_flags"}, {29'd0, done_missaligned, done_unknown_type, done_access_fault},
          {29'd0, mis && !unk, unk, 1'b0});
      chk({tag, ":err_nobus"}, {30'd0, m_valid, req_ready}, 32'd0);
      exp_done++;
      tick();
      chk({tag, ":err_after"}, {30'd0, done_valid, req_ready}, 32'd1);
    end else begin
      for (int k = 0; k <= rdly; k++) begin
        chk({tag, ":m_valid"}, {30'd0, m_valid, done_valid}, 32'd2);
        chk({tag, ":m_addr"}, m_addr, exp_addr);
        chk({tag, ":m_wdata"}, m_wdata, wd);
        chk({tag, ":m_wstrb"}, {28'd0, m_wstrb}, {28'd0, strb});
        m_ready = (k == rdly);
        tick();
      end
      m_ready = 1'b0;
      chk({tag, ":m_valid_drop"}, {31'd0, m_valid}, 32'd0);
      for (int k = 0; k < pdly; k++) begin
        chk({tag, ":wait_resp"}, {30'd0, done_valid, req_ready}, 32'd0);
        tick();
      end
      m_resp_valid = 1'b1; m_resp_error = perr;
      tick();
      m_resp_valid = 1'b0; m_resp_error = 1'b0;
      chk({tag, ":done"}, {30'd0, done_valid, req_ready}, 32'd3);
      chk({tag, ":done_flags"}, {29'd0, done_missaligned, done_unknown_type, done_access_fault},
          {31'd0, perr});
      exp_done++;
      tick();
      chk({tag, ":done_clear"}, {31'd0, done_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    logic mis, unk;
    logic [3:0] strb;
    logic [31:0] wd;
    logic [2:0] t;
    logic [31:0] a, d;

    vecs[0] = '{"sb_1003",   3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 1'b0, 1'b0, 1'b0, 4'b1000, 32'hDDDD_DDDD};
    vecs[1] = '{"sh_2002",   3'b001, 32'h0000_2002, 32'h0000_1234, 3, 0, 1'b0, 1'b0, 1'b0, 4'b1100, 32'h1234_1234};
    vecs[2] = '{"sw_mis",    3'b010, 32'h0000_3001, 32'h1111_2222, 0, 0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0};
    vecs[3] = '{"unk_3001",  3'b011, 32'h0000_3001, 32'h1111_2222, 0, 0, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0};
    vecs[4] = '{"sw_fault",  3'b010, 32'h0000_4000, 32'hCAFE_BABE, 0, 2, 1'b1, 1'b0, 1'b0, 4'b1111, 32'hCAFE_BABE};
    vecs[5] = '{"sh_mis",    3'b001, 32'h0000_2001, 32'h0000_5678, 0, 0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0};
    vecs[6] = '{"sb_0010",   3'b000, 32'h0000_0010, 32'h0000_0055, 1, 1, 1'b0, 1'b0, 1'b0, 4'b0001, 32'h5555_5555};
    vecs[7] = '{"sh_0000",   3'b001, 32'h0000_0000, 32'hFFFF_8001, 0, 3, 1'b0, 1'b0, 1'b0, 4'b0011, 32'h8001_8001};
    vecs[8] = '{"unk7",      3'b111, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0};

    rst = 1'b1; req_valid = 1'b0; req_type = '0; req_addr = '0; req_data = '0;
    m_ready = 1'b0; m_resp_valid = 1'b0; m_resp_error = 1'b0;
    tick(); tick();
    chk("reset_ctl", {28'd0, req_ready, m_valid, done_valid, m_wstrb == 4'd0}, 32'b1001);
    chk("reset_addr", m_addr, 32'd0);
    chk("reset_wdata", m_wdata, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    foreach (vecs[i])
      run_txn(vecs[i].name, vecs[i].typ, vecs[i].addr, vecs[i].data, vecs[i].rdly,
              vecs[i].pdly, vecs[i].perr, vecs[i].exp_mis, vecs[i].exp_unk,
              vecs[i].exp_strb, vecs[i].exp_wdata);

    // Back-to-back: req_valid held, second SW accepted in the first done cycle.
    req_valid = 1'b1; req_type = 3'b010; req_addr = 32'h0000_5000; req_data = 32'h0101_0101;
    tick();
    req_addr = 32'h0000_5004; req_data = 32'h0202_0202;
    chk("b2b_first_addr", m_addr, 32'h0000_5000);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; m_resp_valid = 1'b1;
    tick();
    m_resp_valid = 1'b0;
    chk("b2b_done1", {30'd0, done_valid, req_ready}, 32'd3);
    exp_done++;
    tick();
    req_valid = 1'b0;
    chk("b2b_second_bus", {30'd0, m_valid, done_valid}, 32'd2);
    chk("b2b_second_addr", m_addr, 32'h0000_5004);
    chk("b2b_second_data", m_wdata, 32'h0202_0202);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; m_resp_valid = 1'b1;
    tick();
    m_resp_valid = 1'b0;
    chk("b2b_done2", {31'd0, done_valid}, 32'd1);
    exp_done++;
    tick();

    // Reset while waiting for the response, then a late response must be ignored.
    req_valid = 1'b1; req_type = 3'b000; req_addr = 32'h0000_6002; req_data = 32'h0000_00A5;
    tick();
    req_valid = 1'b0; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("rst_in_resp", {30'd0, m_valid, req_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_state", {28'd0, req_ready, m_valid, done_valid, m_wstrb == 4'd0}, 32'b1001);
    chk("rst_addr", m_addr, 32'd0);
    chk("rst_wdata", m_wdata, 32'd0);
    m_resp_valid = 1'b1;
    tick();
    m_resp_valid = 1'b0;
    chk("rst_late_resp", {30'd0, done_valid, req_ready}, 32'd1);
    tick();
    chk("rst_late_resp2", {30'd0, done_valid, m_valid}, 32'd0);

    // Randomized transactions against the size/offset model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) t = 3'($urandom_range(3, 7));
      else t = 3'($urandom_range(0, 2));
      a = $urandom; d = $urandom;
      model(t, a, d, mis, unk, strb, wd);
      run_txn($sformatf("rnd%0d", n), t, a, d, $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), mis, unk, strb, wd);
    end

    tick();
    chk("done_count", done_seen, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/corevx_storegen.md
Name: corevx_storegen

Overview:
- Store-side counterpart of the load path: takes one store request from the execute stage and checks its type and alignment.
- Builds a word-aligned bus write (address, replicated data, byte strobes).
- Runs a valid/ready handshake to the data-memory port and waits for the write response.
- Reports completion or error to the pipeline with a single-cycle done pulse.

Parameters:
- none

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  store request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_type  input  3  store type: 3'b000 SB, 3'b001 SH, 3'b010 SW; all other encodings unknown
- req_addr  input  32  byte address
- req_data  input  32  store data, right-aligned
- m_valid  output  1  bus write request valid
- m_ready  input  1  bus accepts write
- m_addr  output  32  word address {req_addr[31:2],2'b00}
- m_wdata  output  32  write data
- m_wstrb  output  4  byte strobes, bit i = byte lane i
- m_resp_valid  input  1  write response
- m_resp_error  input  1  access fault, qualified by m_resp_valid
- done_valid  output  1  one-cycle completion pulse
- done_missaligned  output  1  misaligned store, qualified by done_valid
- done_unknown_type  output  1  unknown req_type, qualified by done_valid
- done_access_fault  output  1  bus returned error, qualified by done_valid

Behaviour:
- All outputs are registered except req_ready, which is decoded from state.
- Reset values: state IDLE; m_valid, done_* and m_wstrb all 0; m_addr and m_wdata 0.
- States: IDLE, BUS_REQ, BUS_RESP, ERR.
- IDLE: req_ready=1. On req_valid, the request is accepted and decoded:
  - Unknown type -> go to ERR with unknown=1 and missaligned=0. Unknown takes precedence over misalignment.
  - SW with addr[1:0]!=0, or SH with addr[0]=1 -> go to ERR with missaligned=1.
  - Otherwise latch the bus fields below and go to BUS_REQ.
- Bus field encoding (off = addr[1:0]):
  - SB: wstrb = 4'b0001<<off; wdata = {4{data[7:0]}}.
  - SH: wstrb = 4'b0011<<off; wdata = {2{data[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = data.
- ERR: lasts one cycle. done_valid=1 with the latched error flags; no bus traffic is issued. Next state is IDLE.
- BUS_REQ: m_valid=1. m_addr, m_wdata and m_wstrb stay stable until m_ready. On m_valid&&m_ready: m_valid drops the next cycle and state goes to BUS_RESP.
- BUS_RESP: wait an unbounded number of cycles for m_resp_valid. On m_resp_valid: the next cycle has done_valid=1 and done_access_fault=m_resp_error, and state is IDLE.
  - m_resp_valid outside BUS_RESP is ignored. The bus guarantees a response no earlier than the cycle after acceptance.
- done_valid is high in the first IDLE cycle, and req_ready is also high then. A new request can therefore be accepted in the same cycle as the previous done pulse.
- done_* flags are 0 whenever done_valid=0. Exactly one done pulse is produced per accepted request.
- Minimum latency:
  - Accept at cycle 0; m_valid at cycle 1.
  - With m_ready at cycle 1 and response at cycle 2, done_valid is at cycle 3.
  - Error path: done_valid at cycle 1.
- Reset mid-operation: rst overrides everything and returns to IDLE with reset values.
  - Any outstanding request is abandoned and produces no done pulse.
  - The memory port shares the same rst.
- req_* inputs are sampled only on acceptance; later changes have no effect on the request in flight.

Test Plan:
- SB: addr=0x1003, data=0xAABBCCDD, m_ready=1, resp 1 cycle later -> m_addr=0x1000, m_wstrb=4'b1000, m_wdata=0xDDDDDDDD; done_valid at cycle 3 with all flags 0.
- SH: addr=0x2002, data=0x00001234, m_ready held low 3 cycles -> m_valid and fields stable for 4 cycles; m_wstrb=4'b1100, m_wdata=0x12341234; done follows the response.
- SW: addr=0x3001 -> no m_valid; done_valid at cycle 1 with done_missaligned=1. Then type 3'b011 at addr=0x3001 -> done_unknown_type=1, missaligned=0.
- SW: addr=0x4000, data=0xCAFEBABE, m_resp_error=1 -> m_wstrb=4'hF; done_access_fault=1.
- Back-to-back: hold req_valid with two SW requests -> second accepted in the first request's done cycle; exactly two done pulses.
- Assert rst while in BUS_RESP, then send a late m_resp_valid -> no done pulse; state IDLE with req_ready=1 and outputs at reset values.
